// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters,
// with bounded bursts per grant and a watchdog on the transmitter's busy response.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BIT_NUM = 8,
    parameter int MAX_BURST    = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*DATA_BIT_NUM-1:0] data_i,
    output logic [NUM_REQ-1:0]              ack_o,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic [DATA_BIT_NUM-1:0]         tx_data_o,
    output logic                            tx_start_o,
    input  logic                            tx_busy_i,
    output logic                            timeout_o
);

    localparam int OWNER_W = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int TIMER_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state;
    logic [OWNER_W-1:0]      owner;
    logic [OWNER_W-1:0]      last_owner;
    logic [BURST_W-1:0]      burst_cnt;
    logic [TIMER_W-1:0]      timer;

    logic [OWNER_W-1:0]      winner;
    logic [OWNER_W-1:0]      cand;
    logic                    found;
    logic [DATA_BIT_NUM-1:0] owner_data;
    logic [BURST_W-1:0]      burst_inc;

    // Search starts just after the previous owner, so the previous owner is tried last.
    always_comb begin
        winner = last_owner;
        cand   = last_owner;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OWNER_W'((int'(last_owner) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (OWNER_W'(k) == owner) begin
                owner_data = data_i[k*DATA_BIT_NUM +: DATA_BIT_NUM];
            end
        end
    end

    assign burst_inc = (burst_cnt == BURST_W'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            grant_o    <= '0;
            ack_o      <= '0;
            tx_start_o <= 1'b0;
            timeout_o  <= 1'b0;
            tx_data_o  <= '0;
            burst_cnt  <= '0;
            timer      <= '0;
            owner      <= '0;
            last_owner <= OWNER_W'(NUM_REQ - 1);
        end else begin
            // NOTE: strobes default low every cycle; a later assignment in the case overrides.
            ack_o      <= '0;
            tx_start_o <= 1'b0;
            timeout_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!tx_busy_i && found) begin
                        owner   <= winner;
                        grant_o <= NUM_REQ'(1) << winner;
                        state   <= START;
                    end
                end
                START: begin
                    if (req_i[owner]) begin
                        tx_data_o  <= owner_data;
                        tx_start_o <= 1'b1;
                        ack_o      <= grant_o;
                        timer      <= TIMER_W'(BUSY_TIMEOUT - 1);
                        state      <= WAIT_BUSY;
                    end else begin
                        // Withdrawn request: give up the grant without rotating priority.
                        grant_o   <= '0;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        state <= WAIT_DONE;
                    end else if (timer == '0) begin
                        timeout_o  <= 1'b1;
                        grant_o    <= '0;
                        last_owner <= owner;
                        burst_cnt  <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        if (req_i[owner] && (burst_inc < BURST_W'(MAX_BURST))) begin
                            burst_cnt <= burst_inc;
                            state     <= START;
                        end else begin
                            grant_o    <= '0;
                            last_owner <= owner;
                            burst_cnt  <= '0;
                            state      <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester scenarios push expected
// characters; independent monitors compare every strobe and timeout the DUT presents.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int FRAME   = 10;

    typedef struct {
        logic [NUM_REQ-1:0] grant;
        logic [DW-1:0]      data;
        logic               gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset_i = 1'b1;

    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ*DW-1:0] data = '0;
    logic                  busy;
    logic [NUM_REQ-1:0]    ack, grant;
    logic [DW-1:0]         tx_data;
    logic                  tx_start, timeout;

    logic [NUM_REQ-1:0]    req_rr = '0;
    logic [NUM_REQ*DW-1:0] data_rr = '0;
    logic                  busy_rr;
    logic [NUM_REQ-1:0]    ack_rr, grant_rr;
    logic [DW-1:0]         tx_data_rr;
    logic                  tx_start_rr, timeout_rr;

    logic uart_auto = 1'b1;

    exp_t exp_q[$];
    exp_t exp_rr_q[$];
    int   to_q[$];

    int pend[NUM_REQ];
    logic [DW-1:0] nxt[NUM_REQ];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_i      (req),
        .data_i     (data),
        .ack_o      (ack),
        .grant_o    (grant),
        .tx_data_o  (tx_data),
        .tx_start_o (tx_start),
        .tx_busy_i  (busy),
        .timeout_o  (timeout)
    );

    uart_tx_arbiter #(.MAX_BURST(1)) dut_rr (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_i      (req_rr),
        .data_i     (data_rr),
        .ack_o      (ack_rr),
        .grant_o    (grant_rr),
        .tx_data_o  (tx_data_rr),
        .tx_start_o (tx_start_rr),
        .tx_busy_i  (busy_rr),
        .timeout_o  (timeout_rr)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transmitter models: busy rises right after a strobe and lasts FRAME cycles.
    initial begin
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_auto && tx_start) begin
                busy = 1'b1;
                repeat (FRAME) @(negedge clk);
                busy = 1'b0;
            end
        end
    end

    initial begin
        busy_rr = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start_rr) begin
                busy_rr = 1'b1;
                repeat (FRAME) @(negedge clk);
                busy_rr = 1'b0;
            end
        end
    end

    // Monitor for the main instance.
    initial begin : mon_main
        logic [NUM_REQ-1:0] prev_grant;
        logic zero_seen;
        int   since;
        int   to_exp;
        exp_t e;
        prev_grant = '0;
        zero_seen  = 1'b1;
        since      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (busy && !reset_i) check("grant_stable_while_busy", grant, prev_grant);
            check("ack_matches_strobe", ack, tx_start ? grant : '0);
            if (grant == '0) zero_seen = 1'b1;
            since++;
            if (tx_start) begin
                since = 0;
                check("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("strobe_grant", grant, e.grant);
                    check("strobe_data", tx_data, e.data);
                    check("strobe_gap_before", zero_seen, e.gap);
                end
                zero_seen = 1'b0;
            end
            if (timeout) begin
                check("timeout_expected", to_q.size() != 0, 1);
                if (to_q.size() != 0) begin
                    to_exp = to_q.pop_front();
                    check("timeout_latency", since, to_exp);
                    check("timeout_grant_idle", grant, 0);
                end
            end
            prev_grant = grant;
        end
    end

    // Monitor for the single-character-burst instance.
    initial begin : mon_rr
        logic zero_seen;
        exp_t e;
        zero_seen = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            check("rr_ack_matches_strobe", ack_rr, tx_start_rr ? grant_rr : '0);
            check("rr_no_timeout", timeout_rr, 0);
            if (grant_rr == '0) zero_seen = 1'b1;
            if (tx_start_rr) begin
                check("rr_strobe_expected", exp_rr_q.size() != 0, 1);
                check("rr_strobe_after_frame", busy_rr, 0);
                if (exp_rr_q.size() != 0) begin
                    e = exp_rr_q.pop_front();
                    check("rr_owner", grant_rr, e.grant);
                    check("rr_data", tx_data_rr, e.data);
                    check("rr_gap_before", zero_seen, e.gap);
                end
                zero_seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic drive_req();
        for (int k = 0; k < NUM_REQ; k++) begin
            req[k] = (pend[k] > 0);
            data[k*DW +: DW] = nxt[k];
        end
    endtask

    // Requesters: a character is consumed on its ack; the request drops when none remain.
    task automatic tick();
        @(negedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ack[k] && pend[k] > 0) begin
                pend[k]--;
                nxt[k] = nxt[k] + 1'b1;
            end
        end
        drive_req();
    endtask

    task automatic expect_char(input logic [NUM_REQ-1:0] g, input logic [DW-1:0] d, input logic gap);
        exp_q.push_back('{grant: g, data: d, gap: gap});
    endtask

    function automatic bit all_quiet();
        bit q;
        q = (exp_q.size() == 0) && (to_q.size() == 0) && (grant == '0) && !busy;
        for (int k = 0; k < NUM_REQ; k++) if (pend[k] != 0) q = 1'b0;
        return q;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while (!all_quiet() && n < budget) begin
            tick();
            n++;
        end
        check(name, n < budget, 1);
    endtask

    task automatic wait_pend(input int k, input int value, input string name);
        int n;
        n = 0;
        while (pend[k] != value && n < 200) begin
            tick();
            n++;
        end
        check(name, n < 200, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_tx_data"}, tx_data, 0);
    endtask

    initial begin : stimulus
        int n;
        for (int k = 0; k < NUM_REQ; k++) begin
            pend[k] = 0;
            nxt[k]  = '0;
        end
        drive_req();

        // Reset state.
        repeat (3) tick();
        check_all_zero("reset");
        reset_i = 1'b0;
        tick();

        // Single request: grant one cycle later, strobe two cycles later.
        expect_char(4'b0100, 8'hA5, 1'b1);
        pend[2] = 1;
        nxt[2]  = 8'hA5;
        drive_req();
        tick();
        check("single_grant", grant, 4'b0100);
        check("single_no_early_start", tx_start, 0);
        tick();
        check("single_start", tx_start, 1);
        check("single_ack", ack, 4'b0100);
        check("single_data", tx_data, 8'hA5);
        wait_quiet("single_done", 300);

        // Six characters from requester 1: burst of four, re-grant, then two.
        expect_char(4'b0010, 8'h10, 1'b1);
        expect_char(4'b0010, 8'h11, 1'b0);
        expect_char(4'b0010, 8'h12, 1'b0);
        expect_char(4'b0010, 8'h13, 1'b0);
        expect_char(4'b0010, 8'h14, 1'b1);
        expect_char(4'b0010, 8'h15, 1'b0);
        pend[1] = 6;
        nxt[1]  = 8'h10;
        drive_req();
        wait_quiet("burst_done", 500);

        // Requester 0 arrives mid-burst of requester 3 and must wait.
        expect_char(4'b1000, 8'h30, 1'b1);
        expect_char(4'b1000, 8'h31, 1'b0);
        expect_char(4'b0001, 8'h50, 1'b1);
        pend[3] = 2;
        nxt[3]  = 8'h30;
        drive_req();
        wait_pend(3, 1, "holdoff_first_ack");
        pend[0] = 1;
        nxt[0]  = 8'h50;
        drive_req();
        wait_quiet("holdoff_done", 400);

        // Withdraw: requester 2 drops its request while granted.
        pend[2] = 1;
        nxt[2]  = 8'h77;
        drive_req();
        n = 0;
        while (grant == '0 && n < 20) begin
            tick();
            n++;
        end
        check("withdraw_grant", grant, 4'b0100);
        pend[2] = 0;
        drive_req();
        tick();
        check("withdraw_grant_cleared", grant, 0);
        check("withdraw_no_start", tx_start, 0);
        check("withdraw_no_ack", ack, 0);
        tick();
        check("withdraw_still_no_start", tx_start, 0);
        wait_quiet("withdraw_done", 50);

        // Timeout: transmitter never goes busy.
        uart_auto = 1'b0;
        expect_char(4'b0001, 8'h60, 1'b1);
        to_q.push_back(64);
        pend[0] = 1;
        nxt[0]  = 8'h60;
        drive_req();
        wait_pend(0, 0, "timeout_first_ack");
        expect_char(4'b0010, 8'h20, 1'b1);
        expect_char(4'b0001, 8'h61, 1'b1);
        to_q.push_back(64);
        to_q.push_back(64);
        pend[1] = 1;
        nxt[1]  = 8'h20;
        pend[0] = 1;
        drive_req();
        wait_quiet("timeout_done", 600);
        uart_auto = 1'b1;
        tick();

        // Reset in the middle of a frame.
        expect_char(4'b0100, 8'hC3, 1'b1);
        pend[2] = 1;
        nxt[2]  = 8'hC3;
        drive_req();
        n = 0;
        while (!busy && n < 40) begin
            tick();
            n++;
        end
        check("midframe_busy_seen", n < 40, 1);
        repeat (3) tick();
        reset_i = 1'b1;
        tick();
        check_all_zero("midframe_reset");
        reset_i = 1'b0;
        expect_char(4'b0001, 8'h0A, 1'b1);
        expect_char(4'b1000, 8'h3A, 1'b1);
        pend[0] = 1;
        nxt[0]  = 8'h0A;
        pend[3] = 1;
        nxt[3]  = 8'h3A;
        drive_req();
        wait_quiet("midframe_done", 400);

        // Round-robin with single-character bursts, all four requesting.
        exp_rr_q.push_back('{grant: 4'b0001, data: 8'h40, gap: 1'b1});
        exp_rr_q.push_back('{grant: 4'b0010, data: 8'h41, gap: 1'b1});
        exp_rr_q.push_back('{grant: 4'b0100, data: 8'h42, gap: 1'b1});
        exp_rr_q.push_back('{grant: 4'b1000, data: 8'h43, gap: 1'b1});
        exp_rr_q.push_back('{grant: 4'b0001, data: 8'h40, gap: 1'b1});
        data_rr = {8'h43, 8'h42, 8'h41, 8'h40};
        req_rr  = 4'b1111;
        n = 0;
        for (int c = 0; c < 400 && n < 5; c++) begin
            tick();
            if (tx_start_rr) n++;
        end
        check("rr_five_frames", n, 5);
        req_rr = '0;
        n = 0;
        while ((exp_rr_q.size() != 0 || busy_rr || grant_rr != '0) && n < 100) begin
            tick();
            n++;
        end
        check("rr_done", n < 100, 1);
        repeat (5) tick();

        check("leftover_chars", exp_q.size(), 0);
        check("leftover_rr_chars", exp_rr_q.size(), 0);
        check("leftover_timeouts", to_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
